// File: rtl/ps2_kbd_fifo.sv
// PS/2 device-to-host receiver with odd-parity check, stall timeout,
// optional E0/F0 prefix folding and a show-ahead FIFO read via nextdata_n.
module ps2_kbd_fifo #(
    parameter int DEPTH   = 8,
    parameter int MODE    = 1,
    parameter int TIMEOUT = 20000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ps2_clk,
    input  logic                   ps2_data,
    input  logic                   nextdata_n,
    output logic [7:0]             data,
    output logic                   extended,
    output logic                   released,
    output logic                   ready,
    output logic                   overflow,
    output logic                   frame_err,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [2:0]    r_ck_sync;
    logic [1:0]    r_dt_sync;
    logic [3:0]    r_bitcnt;
    logic [9:0]    r_shift;
    logic [TW-1:0] r_idle;
    logic          r_frm_vld;
    logic [7:0]    r_frm_byte;
    logic          r_err;
    logic          r_ext_pend;
    logic          r_brk_pend;
    logic          r_push;
    logic [9:0]    r_push_ent;
    logic [9:0]    r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [9:0]    r_last;
    logic          r_nx_prev;
    logic          r_ovf;

    logic          w_fall;
    logic          w_bit;
    logic          w_frm_ok;
    logic [AW:0]   w_count;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_wr;

    // Index 0 is the first stage of each synchroniser chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ck_sync <= 3'b111;
            r_dt_sync <= 2'b11;
        end else begin
            r_ck_sync <= {r_ck_sync[1:0], ps2_clk};
            r_dt_sync <= {r_dt_sync[0], ps2_data};
        end
    end

    assign w_fall   = !r_ck_sync[1] && r_ck_sync[2];
    assign w_bit    = r_dt_sync[1];
    // r_shift holds start in [0], data in [8:1], parity in [9].
    assign w_frm_ok = !r_shift[0] && w_bit && (^r_shift[9:1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bitcnt   <= '0;
            r_shift    <= '0;
            r_idle     <= '0;
            r_frm_vld  <= 1'b0;
            r_frm_byte <= '0;
            r_err      <= 1'b0;
        end else begin
            r_frm_vld <= 1'b0;
            if (w_fall) begin
                r_idle <= '0;
                if (r_bitcnt == 4'd10) begin
                    r_bitcnt   <= '0;
                    r_frm_vld  <= w_frm_ok;
                    r_frm_byte <= r_shift[8:1];
                    if (!w_frm_ok) r_err <= 1'b1;
                end else begin
                    r_bitcnt <= r_bitcnt + 4'd1;
                    r_shift  <= {w_bit, r_shift[9:1]};
                end
            end else if (r_bitcnt != 4'd0) begin
                if (r_idle == TW'(TIMEOUT - 1)) begin
                    r_bitcnt <= '0;
                    r_idle   <= '0;
                end else begin
                    r_idle <= r_idle + 1'b1;
                end
            end else begin
                r_idle <= '0;
            end
        end
    end

    // Prefix bytes only arm flags; the next ordinary byte carries them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_push     <= 1'b0;
            r_push_ent <= '0;
            r_ext_pend <= 1'b0;
            r_brk_pend <= 1'b0;
        end else begin
            r_push <= 1'b0;
            if (r_frm_vld) begin
                if (MODE == 1 && r_frm_byte == 8'hE0) begin
                    r_ext_pend <= 1'b1;
                end else if (MODE == 1 && r_frm_byte == 8'hF0) begin
                    r_brk_pend <= 1'b1;
                end else begin
                    r_push     <= 1'b1;
                    r_push_ent <= {r_ext_pend, r_brk_pend, r_frm_byte};
                    r_ext_pend <= 1'b0;
                    r_brk_pend <= 1'b0;
                end
            end
        end
    end

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_empty = (w_count == '0);
    assign w_full  = (w_count == (AW+1)'(DEPTH));
    assign w_pop   = r_nx_prev && !nextdata_n && !w_empty;
    assign w_wr    = r_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= r_push_ent;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_last    <= '0;
            r_nx_prev <= 1'b1;
            r_ovf     <= 1'b0;
        end else begin
            r_nx_prev <= nextdata_n;
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_last   <= r_mem[r_rd_ptr[AW-1:0]];
                r_ovf    <= 1'b0;
            end else if (r_push && !w_wr) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // An empty FIFO keeps presenting the entry popped last.
    assign {extended, released, data} =
        w_empty ? r_last : r_mem[r_rd_ptr[AW-1:0]];
    assign ready     = !w_empty;
    assign overflow  = r_ovf;
    assign frame_err = r_err;
    assign count     = w_count;

endmodule

// File: tb/tb_ps2_kbd_fifo.sv
// Bench for ps2_kbd_fifo: a prefix-decoding and a raw instance share the
// PS/2 lines; a queue model per instance is checked by a pop monitor.
module tb_ps2_kbd_fifo;
    localparam int DEPTH = 8;
    localparam int TO    = 300;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       nextdata_n = 1'b1;
    logic [7:0] d1, d0;
    logic       e1, r1, rd1, ov1, fe1;
    logic       e0, r0, rd0, ov0, fe0;
    logic [3:0] c1, c0;

    int n_chk = 0;
    int n_fail = 0;

    logic [9:0] q1[$];
    logic [9:0] q0[$];
    logic [9:0] last1, last0;
    bit ov1m, ov0m, err_m, ext_p, brk_p;
    bit nx_q = 1'b1;

    always #5 clk = ~clk;

    ps2_kbd_fifo #(.DEPTH(DEPTH), .MODE(1), .TIMEOUT(TO)) u_m1 (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .nextdata_n(nextdata_n), .data(d1), .extended(e1),
        .released(r1), .ready(rd1), .overflow(ov1),
        .frame_err(fe1), .count(c1)
    );

    ps2_kbd_fifo #(.DEPTH(DEPTH), .MODE(0), .TIMEOUT(TO)) u_m0 (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .nextdata_n(nextdata_n), .data(d0), .extended(e0),
        .released(r0), .ready(rd0), .overflow(ov0),
        .frame_err(fe0), .count(c0)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a falling nextdata_n is a read; compare head and retire it.
    always @(negedge clk) begin
        if (rst) begin
            nx_q = 1'b1;
        end else begin
            if (nx_q && !nextdata_n) begin
                chk("mon_ready_m1", rd1, q1.size() != 0);
                if (q1.size() != 0) begin
                    chk("mon_head_m1", {e1, r1, d1}, q1[0]);
                    last1 = q1.pop_front();
                    ov1m  = 1'b0;
                end
                chk("mon_ready_m0", rd0, q0.size() != 0);
                if (q0.size() != 0) begin
                    chk("mon_head_m0", {e0, r0, d0}, q0[0]);
                    last0 = q0.pop_front();
                    ov0m  = 1'b0;
                end
            end
            nx_q = nextdata_n;
        end
    end

    task automatic model_frame(input logic [7:0] b, input bit good);
        if (!good) begin
            err_m = 1'b1;
        end else begin
            if (q0.size() == DEPTH) ov0m = 1'b1;
            else q0.push_back({2'b00, b});
            if (b == 8'hE0) begin
                ext_p = 1'b1;
            end else if (b == 8'hF0) begin
                brk_p = 1'b1;
            end else begin
                if (q1.size() == DEPTH) ov1m = 1'b1;
                else q1.push_back({ext_p, brk_p, b});
                ext_p = 1'b0;
                brk_p = 1'b0;
            end
        end
    endtask

    task automatic send_bits(input logic [10:0] fr, input int n,
                             input int per, input bit lat);
        int h;
        h = per / 2;
        for (int i = 0; i < n; i++) begin
            ps2_data = fr[i];
            repeat (h) tick();
            ps2_clk = 1'b0;
            if (lat && i == 10) begin
                repeat (4) tick();
                chk("latency_not_yet", rd1, 1'b0);
                tick();
                chk("latency_ready", rd1, 1'b1);
                repeat (h - 5) tick();
            end else begin
                repeat (h) tick();
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit good,
                              input int per, input bit lat);
        logic par;
        par = good ? ~^b : ^b;
        send_bits({1'b1, par, b, 1'b0}, 11, per, lat);
        model_frame(b, good);
    endtask

    task automatic pop_once(input int hold);
        tick();
        nextdata_n = 1'b0;
        repeat (hold) tick();
        nextdata_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        nextdata_n = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        q1.delete();
        q0.delete();
        last1 = '0;
        last0 = '0;
        ov1m = 1'b0;
        ov0m = 1'b0;
        err_m = 1'b0;
        ext_p = 1'b0;
        brk_p = 1'b0;
        tick();
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_cnt_m1"}, c1, q1.size());
        chk({tag, "_cnt_m0"}, c0, q0.size());
        chk({tag, "_rdy_m1"}, rd1, q1.size() != 0);
        chk({tag, "_rdy_m0"}, rd0, q0.size() != 0);
        chk({tag, "_ovf_m1"}, ov1, ov1m);
        chk({tag, "_ovf_m0"}, ov0, ov0m);
        chk({tag, "_ferr_m1"}, fe1, err_m);
        chk({tag, "_ferr_m0"}, fe0, err_m);
        chk({tag, "_head_m1"}, {e1, r1, d1},
            q1.size() != 0 ? q1[0] : last1);
        chk({tag, "_head_m0"}, {e0, r0, d0},
            q0.size() != 0 ? q0[0] : last0);
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog: cycle budget exceeded, required finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        int r;
        do_reset();
        check_state("reset");

        send_frame(8'h1C, 1'b1, 60, 1'b1);
        check_state("byte1c");
        tick();
        nextdata_n = 1'b0;
        tick();
        chk("pop_ready_m1", rd1, 1'b0);
        chk("pop_count_m1", c1, 4'd0);
        nextdata_n = 1'b1;
        repeat (2) tick();
        check_state("after_pop");

        do_reset();
        send_frame(8'hE0, 1'b1, 60, 1'b0);
        send_frame(8'hF0, 1'b1, 60, 1'b0);
        send_frame(8'h75, 1'b1, 60, 1'b0);
        check_state("e0f075");
        send_frame(8'h1C, 1'b1, 60, 1'b0);
        check_state("prefix_then_1c");
        repeat (4) pop_once(2);
        check_state("prefix_drained");

        do_reset();
        send_frame(8'h1C, 1'b0, 60, 1'b0);
        check_state("bad_parity");
        send_frame(8'h32, 1'b1, 60, 1'b0);
        check_state("after_bad");
        pop_once(1);
        check_state("ferr_sticky");
        do_reset();
        check_state("ferr_cleared");

        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, 60, 1'b0);
        check_state("full");
        pop_once(1);
        check_state("full_pop1");
        repeat (8) pop_once(1);
        check_state("full_drained");

        do_reset();
        send_bits({1'b1, 1'b0, 8'h55, 1'b0}, 5, 60, 1'b0);
        repeat (TO + 10) tick();
        send_frame(8'h2A, 1'b1, 60, 1'b0);
        check_state("timeout");
        pop_once(1);
        send_bits({1'b1, 1'b0, 8'h55, 1'b0}, 5, 60, 1'b0);
        do_reset();
        send_frame(8'h4B, 1'b1, 60, 1'b0);
        check_state("rst_midframe");

        do_reset();
        send_frame(8'hF0, 1'b1, 60, 1'b0);
        send_frame(8'h1C, 1'b1, 60, 1'b0);
        check_state("raw_f01c");
        pop_once(50);
        check_state("hold_low");
        pop_once(1);
        check_state("raw_drained");

        do_reset();
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 99);
            if (r < 15) b = 8'hE0;
            else if (r < 30) b = 8'hF0;
            else b = 8'($urandom_range(0, 255));
            send_frame(b, $urandom_range(0, 99) >= 5,
                       2 * $urandom_range(15, 40), 1'b0);
            if ($urandom_range(0, 9) == 0) begin
                send_bits(11'($urandom), $urandom_range(1, 9), 60, 1'b0);
                repeat (TO + 10) tick();
            end
            if ($urandom_range(0, 99) < 40)
                repeat ($urandom_range(1, 3)) pop_once($urandom_range(1, 5));
            check_state("rand");
        end
        repeat (10) pop_once(1);
        check_state("rand_drained");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_kbd_fifo.md
Name: ps2_kbd_fifo

Overview:
- Parametrised successor to the single-byte PS/2 receiver in the keyboard/7-seg display path.
- Deserialises PS/2 device-to-host frames and checks start, stop and odd parity.
- Aborts stalled frames on a timeout.
- Optionally folds E0/F0 prefix bytes into flags on the following scan code.
- Buffers results in a show-ahead FIFO of configurable depth, read by the display/CPU side via the existing nextdata_n handshake.

Parameters:
- DEPTH, 8, number of FIFO entries; power of 2, minimum 2.
- MODE, 1, 0 = raw bytes, every valid byte queued with both flags 0; 1 = prefix decode.
- TIMEOUT, 20000, clk cycles without a ps2_clk falling edge before a partial frame is discarded.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- ps2_clk  in  1  PS/2 clock line, asynchronous to clk.
- ps2_data  in  1  PS/2 data line, asynchronous to clk.
- nextdata_n  in  1  active-low read request, level input; edge-detected internally.
- data  out  8  scan code at the FIFO head.
- extended  out  1  head entry was preceded by E0 (MODE=1).
- released  out  1  head entry was preceded by F0 (MODE=1).
- ready  out  1  FIFO not empty.
- overflow  out  1  at least one entry dropped since the last pop.
- frame_err  out  1  sticky: a frame failed start/stop/parity check.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst=1 at a clk edge):
  - All state cleared: FIFO empty, bit counter 0, prefix flags 0.
  - Outputs: ready=0, overflow=0, frame_err=0, count=0, data/extended/released=0.
  - Sync flops and the nextdata_n history register reset to 1.
  - Reset mid-frame discards the partial frame.
- Synchroniser: ps2_clk passes through 3 flops. fall = (stage2==0 && stage3==1), a single-cycle pulse. ps2_data is sampled from its own 2-flop synchroniser on the fall cycle.
- Frame format: 11 bits, LSB first: start(0), d0..d7, parity, stop(1). A 4-bit counter runs 0..10 and increments on each fall.
- Frame check on the 11th fall:
  - Valid iff start==0, stop==1, and XOR(d7..d0, parity)==1.
  - Counter returns to 0 whether or not the frame is valid.
  - Invalid frame: byte discarded, frame_err<=1. frame_err is cleared only by rst.
- Timeout: with counter!=0, an idle counter increments each clk and clears on fall. When it reaches TIMEOUT, the bit counter <=0. frame_err is not set.
- Decode, MODE=1:
  - Valid byte E0: set ext_pend, no push.
  - Valid byte F0: set brk_pend, no push.
  - Any other valid byte: push {ext_pend, brk_pend, byte}, then clear both pends.
  - E0 F0 xx, or F0 E0 xx, yields one entry with both flags set.
- Decode, MODE=0: every valid byte is pushed with flags 0.
- Latency: ready rises exactly 4 clk edges after the clk edge at which synchroniser stage1 first samples the stop-bit ps2_clk low. This is true for every pushed byte on an empty FIFO.
- FIFO:
  - DEPTH x 10 bits, read/write pointers with an extra wrap bit.
  - count = wr_ptr - rd_ptr.
  - Full when count==DEPTH; empty when count==0.
  - Outputs are show-ahead: data/extended/released always reflect the head entry. When empty they hold the last popped value (0 after reset).
- Pop:
  - nx_prev is a register of nextdata_n.
  - pop = nx_prev==1 && nextdata_n==0 && ready.
  - Exactly one entry per falling edge of nextdata_n. Holding it low does not pop again. A falling edge while empty is ignored.
- Push acceptance: a push is accepted if count<DEPTH or pop occurs the same cycle. A simultaneous push and pop on a full FIFO leaves count unchanged and sets no overflow.
- Overflow:
  - A push rejected on a full FIFO drops the new entry (oldest data is preserved) and sets overflow<=1.
  - overflow clears on the next pop cycle.
- Push and pop on an empty FIFO in the same cycle: pop is not possible (ready=0); the push proceeds.

Test Plan:
- Frame 0x1C, valid parity (parity bit=0), ps2_clk period 60 clk -> ready=1 exactly 4 clk after the stop-bit fall; data=0x1C, extended=0, released=0, count=1. Then a nextdata_n 1->0 -> ready=0 next cycle, count=0.
- MODE=1, frames E0, F0, 75 -> a single entry: data=0x75, extended=1, released=1, count=1. Next frame 0x1C -> second entry with flags 0.
- Frame 0x1C with parity bit 1 -> no push, count stays 0, frame_err=1 until rst. A subsequent valid 0x32 -> queued normally.
- DEPTH=8: send bytes 0x01..0x09 with no pop -> count=8, overflow=1, head data=0x01. One pop -> data=0x02, overflow=0, count=7. Further pops drain 0x03..0x08 in order; 0x09 is never seen.
- Send 5 bits of a frame, idle TIMEOUT+10 clk, then a full frame 0x2A -> data=0x2A, frame_err=0. Repeat the partial frame with rst asserted mid-frame -> the next full frame is received correctly.
- MODE=0: frames F0, 1C -> two entries: 0xF0 then 0x1C, both flags 0. Hold nextdata_n low for 50 clk -> exactly one pop.
